// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one outstanding access, width/alignment checks,
// lane steering for stores and sign/zero extension for loads.
module riscv_lsu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGN = 32,
    parameter int unsigned REGA = $clog2(REGN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [REGA-1:0] req_rd,
    output logic            resp_valid,
    output logic            resp_we,
    output logic [REGA-1:0] resp_rd,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            stall
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e          r_state;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [REGA-1:0] r_rd;

    logic            w_fault;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;

    assign req_ready = (r_state == StIdle);
    assign stall     = (req_valid && !req_ready) || (r_state != StIdle);

    always_comb begin
        w_fault = 1'b0;
        case (req_funct3)
            3'd0:    w_fault = 1'b0;
            3'd1:    w_fault = req_addr[0];
            3'd2:    w_fault = |req_addr[1:0];
            3'd4:    w_fault = req_store;
            3'd5:    w_fault = req_store | req_addr[0];
            default: w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_off)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        w_load = bus_rdata;
        case (r_funct3)
            3'd0:    w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'd1:    w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'd4:    w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'd5:    w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_store    <= 1'b0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_rd       <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= 4'b0000;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rd    <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        r_rd     <= req_rd;
                        if (w_fault) begin
                            // Faults complete without touching the bus.
                            r_state    <= StDone;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_we    <= 1'b0;
                            resp_rd    <= req_rd;
                            resp_rdata <= '0;
                        end else begin
                            r_state   <= StBus;
                            bus_req   <= 1'b1;
                            bus_we    <= req_store;
                            bus_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            bus_wdata <= w_wdata;
                            bus_wstrb <= req_store ? w_wstrb : 4'b0000;
                        end
                    end
                end
                StBus: begin
                    if (bus_ack) begin
                        r_state    <= StDone;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_wstrb  <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_we    <= !r_store;
                        resp_rd    <= r_rd;
                        resp_rdata <= r_store ? '0 : w_load;
                    end
                end
                StDone: begin
                    r_state    <= StIdle;
                    resp_valid <= 1'b0;
                    resp_we    <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads, stores, faults, wait states and
// reset during an outstanding bus access.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(32), .REGN(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .stall      (stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access; dly is the number of wait cycles before bus_ack.
    task automatic xact(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int dly, input logic [31:0] rdat, input logic exp_fault,
                        input logic [31:0] exp_rdata, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_strb);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        #1;
        check({tag, ".ready_pre"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        if (exp_fault) begin
            check({tag, ".no_bus"},     32'(bus_req),    32'd0);
            check({tag, ".rvalid"},     32'(resp_valid), 32'd1);
            check({tag, ".fault"},      32'(resp_fault), 32'd1);
            check({tag, ".we"},         32'(resp_we),    32'd0);
            check({tag, ".rdata"},      resp_rdata,      32'd0);
            check({tag, ".rd"},         32'(resp_rd),    32'(rd));
            tick();
            check({tag, ".rvalid_end"}, 32'(resp_valid), 32'd0);
            check({tag, ".ready_end"},  32'(req_ready),  32'd1);
        end else begin
            check({tag, ".breq"},  32'(bus_req),   32'd1);
            check({tag, ".baddr"}, bus_addr,       addr & 32'hFFFF_FFFC);
            check({tag, ".bwe"},   32'(bus_we),    32'(st));
            check({tag, ".strb"},  32'(bus_wstrb), 32'(exp_strb));
            if (st) check({tag, ".bwdata"}, bus_wdata, exp_wdata);
            check({tag, ".stall"}, 32'(stall),     32'd1);
            check({tag, ".ready"}, 32'(req_ready), 32'd0);
            for (int i = 0; i < dly; i++) begin
                tick();
                check({tag, ".hold_breq"},  32'(bus_req),    32'd1);
                check({tag, ".hold_addr"},  bus_addr,        addr & 32'hFFFF_FFFC);
                check({tag, ".hold_stall"}, 32'(stall),      32'd1);
                check({tag, ".hold_ready"}, 32'(req_ready),  32'd0);
                check({tag, ".hold_rv"},    32'(resp_valid), 32'd0);
            end
            bus_ack   = 1'b1;
            bus_rdata = rdat;
            tick();
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            check({tag, ".rvalid"}, 32'(resp_valid), 32'd1);
            check({tag, ".fault"},  32'(resp_fault), 32'd0);
            check({tag, ".we"},     32'(resp_we),    32'(!st));
            check({tag, ".rd"},     32'(resp_rd),    32'(rd));
            check({tag, ".rdata"},  resp_rdata,      exp_rdata);
            check({tag, ".breq_off"}, 32'(bus_req),  32'd0);
            tick();
            check({tag, ".rvalid_end"}, 32'(resp_valid), 32'd0);
            check({tag, ".ready_end"},  32'(req_ready),  32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst.ready",  32'(req_ready),  32'd1);
        check("rst.breq",   32'(bus_req),    32'd0);
        check("rst.rvalid", 32'(resp_valid), 32'd0);
        check("rst.stall",  32'(stall),      32'd0);
        check("rst.rdata",  resp_rdata,      32'd0);
        check("rst.strb",   32'(bus_wstrb),  32'd0);

        // Stray ack while idle must not produce a response.
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("idle_ack.rvalid", 32'(resp_valid), 32'd0);

        //    tag    st    f3    addr          wdata         rd  dly rdata         flt   exp_rdata     exp_wdata     strb
        xact("lw",   1'b0, 3'd2, 32'h0000_0100, 32'h0,        5'd5,  0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h0,        4'b0000);
        xact("lb",   1'b0, 3'd0, 32'h0000_0103, 32'h0,        5'd6,  0, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 32'h0,        4'b0000);
        xact("lbu",  1'b0, 3'd4, 32'h0000_0103, 32'h0,        5'd7,  0, 32'h80FF_0000, 1'b0, 32'h0000_0080, 32'h0,        4'b0000);
        xact("lb1",  1'b0, 3'd0, 32'h0000_0101, 32'h0,        5'd8,  0, 32'h0000_7F00, 1'b0, 32'h0000_007F, 32'h0,        4'b0000);
        xact("lh",   1'b0, 3'd1, 32'h0000_0102, 32'h0,        5'd9,  0, 32'h80FF_0000, 1'b0, 32'hFFFF_80FF, 32'h0,        4'b0000);
        xact("lhu",  1'b0, 3'd5, 32'h0000_0100, 32'h0,        5'd10, 0, 32'h1234_F00D, 1'b0, 32'h0000_F00D, 32'h0,        4'b0000);
        xact("sh",   1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd11, 0, 32'h0,        1'b0, 32'h0,        32'hABCD_ABCD, 4'b1100);
        xact("sb",   1'b1, 3'd0, 32'h0000_0301, 32'h0000_00A5, 5'd12, 0, 32'h0,        1'b0, 32'h0,        32'hA5A5_A5A5, 4'b0010);
        xact("sw",   1'b1, 3'd2, 32'h0000_0400, 32'hCAFE_F00D, 5'd13, 0, 32'h0,        1'b0, 32'h0,        32'hCAFE_F00D, 4'b1111);
        xact("lwmis",1'b0, 3'd2, 32'h0000_0101, 32'h0,        5'd14, 0, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000);
        xact("swmis",1'b1, 3'd2, 32'h0000_0402, 32'h1,        5'd15, 0, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000);
        xact("lhmis",1'b0, 3'd1, 32'h0000_0103, 32'h0,        5'd16, 0, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000);
        xact("sbu",  1'b1, 3'd4, 32'h0000_0100, 32'h1,        5'd17, 0, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000);
        xact("f3_3", 1'b0, 3'd3, 32'h0000_0100, 32'h0,        5'd18, 0, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000);
        xact("lwdly",1'b0, 3'd2, 32'h0000_0600, 32'h0,        5'd19, 3, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 32'h0,        4'b0000);

        // Reset while the bus access is outstanding.
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0500;
        req_rd     = 5'd20;
        tick();
        req_valid = 1'b0;
        check("rstbus.breq_pre", 32'(bus_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstbus.breq",   32'(bus_req),    32'd0);
        check("rstbus.ready",  32'(req_ready),  32'd1);
        check("rstbus.rvalid", 32'(resp_valid), 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        bus_ack = 1'b0;
        check("rstbus.ack_rv",   32'(resp_valid), 32'd0);
        check("rstbus.ack_breq", 32'(bus_req),    32'd0);
        tick();
        check("rstbus.late_rv",  32'(resp_valid), 32'd0);
        check("rstbus.rdata",    resp_rdata,      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have parameter REGN, default 32, register count; REGA = $clog2(REGN).
REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have req_valid  input  1  memory-stage request present.
REQ-006 SHALL have req_ready  output  1  LSU can accept a request.
REQ-007 SHALL have req_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have req_funct3  input  3  RV32I width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-009 SHALL have req_addr  input  XLEN  byte address.
REQ-010 SHALL have req_wdata  input  XLEN  store data, right-aligned.
REQ-011 SHALL have req_rd  input  REGA  load destination register.
REQ-012 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have resp_we  output  1  register write enable; 1 only for a fault-free load.
REQ-014 SHALL have resp_rd  output  REGA  destination register.
REQ-015 SHALL have resp_rdata  output  XLEN  extended load data.
REQ-016 SHALL have resp_fault  output  1  misaligned access or illegal funct3.
REQ-017 SHALL have bus_req  output  1  bus request, held until acknowledged.
REQ-018 SHALL have bus_we  output  1  bus write.
REQ-019 SHALL have bus_addr  output  XLEN  word address, bits [1:0] = 0.
REQ-020 SHALL have bus_wdata  output  XLEN  lane-replicated store data.
REQ-021 SHALL have bus_wstrb  output  4  byte enables.
REQ-022 SHALL have bus_ack  input  1  bus completion, one cycle.
REQ-023 SHALL have bus_rdata  input  XLEN  read word, valid with bus_ack.
REQ-024 SHALL have stall  output  1  upstream pipeline hold.

Function
REQ-025 SHALL use FSM states IDLE, BUS, DONE.
REQ-026 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-027 SHALL combinationally drive stall = req_valid && !req_ready, or state != IDLE.
REQ-028 SHALL, on accept, register store, funct3, addr[1:0], rd and wdata.
REQ-029 SHALL fault on accept if: funct3 is 3, 6 or 7; a store has funct3 > 2; H/HU has addr[0] = 1; W has addr[1:0] != 0.
REQ-030 SHALL go from IDLE to DONE on a faulting accept, with no bus activity.
REQ-031 SHALL go from IDLE to BUS on a clean accept.
REQ-032 SHALL, in BUS, hold bus_req = 1 and all bus outputs stable until bus_ack, then capture bus_rdata and go to DONE.
REQ-033 SHALL, in DONE, assert resp_valid for exactly one cycle, then return to IDLE.
REQ-034 SHALL, with zero-wait ack, give latency: accept at edge T, bus_req high after T, ack sampled at T+1, resp_valid high after T+1 (2 cycles).
REQ-035 SHALL set store strobes: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << {addr[1],1'b0}; SW = 4'b1111.
REQ-036 SHALL set store data: SB = byte replicated x4; SH = halfword replicated x2.
REQ-037 SHALL load the byte or halfword selected by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes the word through.
REQ-038 SHALL drive resp_rdata = 0 on stores and faults.
REQ-039 SHALL ignore bus_ack outside BUS.
REQ-040 SHALL ignore req_valid while not IDLE; the request must be held by upstream.

Reset
REQ-041 SHALL, while rst is high at a clk edge, enter IDLE and clear all registered outputs: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, resp_valid, resp_we, resp_rd, resp_rdata, resp_fault.
REQ-042 SHALL abandon an in-flight access (BUS or DONE) on reset: no resp_valid, and a later bus_ack is ignored.

Verification
REQ-043 LW addr 0x100, ack next cycle with rdata 0xDEADBEEF -> bus_addr 0x100, wstrb 0, resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, resp_we 1.
REQ-044 LB addr 0x103, rdata 0x80FF_0000 -> resp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-045 SH addr 0x202, wdata 0x1234ABCD -> bus_wdata 0xABCDABCD, wstrb 4'b1100, bus_we 1, resp_we 0.
REQ-046 LW addr 0x101 -> no bus_req; resp_fault 1 one cycle after accept; resp_we 0.
REQ-047 LW with bus_ack delayed 3 cycles -> bus_req, bus_addr and stall held; req_ready 0 throughout; single resp_valid.
REQ-048 rst asserted during BUS, then bus_ack -> bus_req 0 after the reset edge; no resp_valid; req_ready 1.
